// File: rtl/uart_regfile_mc.sv
// Multi-channel UART register block: per-channel TX/RX byte FIFOs, cfg byte,
// sticky W1C overflow flags and a registered interrupt behind one wr/rd bus.
module uart_regfile_mc #(
  parameter int         NCH        = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CFG_RST    = 8'd18
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               wr_en,
  input  logic [3:0]         be,
  input  logic [15:0]        wr_addr,
  input  logic [31:0]        wdata,
  input  logic               rd_en,
  input  logic [15:0]        rd_addr,
  output logic [31:0]        rdata,
  output logic               rd_rdy,
  output logic [8*NCH-1:0]   uart_cfg,
  output logic [8*NCH-1:0]   tx_data,
  output logic [NCH-1:0]     tx_valid,
  input  logic [NCH-1:0]     tx_ready,
  input  logic [NCH-1:0]     tx_busy,
  input  logic [8*NCH-1:0]   rx_data,
  input  logic [NCH-1:0]     rx_valid,
  output logic [NCH-1:0]     irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [12:0] wr_ch;
  logic [12:0] rd_ch;
  logic        wr_ctrl;
  logic        rd_rx;

  // Channel select is an exact compare, so channels >= NCH never match.
  assign wr_ch   = wr_addr[15:3];
  assign rd_ch   = rd_addr[15:3];
  assign wr_ctrl = wr_en && (wr_addr[2:0] == 3'b000);
  assign rd_rx   = rd_en && (rd_addr[2:0] == 3'b100);

  logic [8*NCH-1:0] status_all;
  logic [8*NCH-1:0] rxcnt_all;
  logic [8*NCH-1:0] txlast_all;
  logic [8*NCH-1:0] rxhead_all;
  logic [NCH-1:0]   rx_ne;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [7:0]    cfg_q, tx_last_q;
    logic          tx_ovf, rx_ovf, irq_q;
    logic          wr_sel, w1c;
    logic          tx_push, tx_pop, tx_wr, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_wr, rx_full, rx_empty;

    assign wr_sel   = wr_ctrl && (wr_ch == 13'(c));
    assign w1c      = wr_sel && be[0];

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = wr_sel && be[1];
    assign tx_pop   = !tx_empty && tx_ready[c];
    // A same-cycle pop frees a slot, so push into a full FIFO is still legal.
    assign tx_wr    = tx_push && (!tx_full || tx_pop);

    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = rx_valid[c];
    assign rx_pop   = rd_rx && (rd_ch == 13'(c)) && !rx_empty;
    assign rx_wr    = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        tx_wp     <= '0;
        tx_rp     <= '0;
        tx_cnt    <= '0;
        rx_wp     <= '0;
        rx_rp     <= '0;
        rx_cnt    <= '0;
        cfg_q     <= CFG_RST;
        tx_last_q <= '0;
        tx_ovf    <= 1'b0;
        rx_ovf    <= 1'b0;
        irq_q     <= 1'b0;
      end else begin
        if (tx_wr)  tx_wp <= tx_wp + 1'b1;
        if (tx_pop) tx_rp <= tx_rp + 1'b1;
        tx_cnt <= tx_cnt + CW'(tx_wr) - CW'(tx_pop);
        if (rx_wr)  rx_wp <= rx_wp + 1'b1;
        if (rx_pop) rx_rp <= rx_rp + 1'b1;
        rx_cnt <= rx_cnt + CW'(rx_wr) - CW'(rx_pop);
        if (wr_sel && be[3]) cfg_q <= wdata[31:24];
        if (tx_push)         tx_last_q <= wdata[15:8];
        // Set terms are OR-ed last so a same-cycle overflow beats the W1C.
        tx_ovf <= (tx_push && !tx_wr) || (tx_ovf && !(w1c && wdata[5]));
        rx_ovf <= (rx_push && !rx_wr) || (rx_ovf && !(w1c && wdata[4]));
        irq_q  <= !rx_empty || rx_ovf || tx_ovf;
      end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and counts
    // define validity, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
      if (tx_wr) tx_mem[tx_wp] <= wdata[15:8];
      if (rx_wr) rx_mem[rx_wp] <= rx_data[8*c +: 8];
    end

    assign tx_data[8*c +: 8]    = tx_mem[tx_rp];
    assign tx_valid[c]          = !tx_empty;
    assign uart_cfg[8*c +: 8]   = cfg_q;
    assign irq[c]               = irq_q;
    assign status_all[8*c +: 8] = {1'b0, tx_busy[c], tx_ovf, rx_ovf,
                                   rx_full, rx_empty, tx_empty, tx_full};
    assign rxcnt_all[8*c +: 8]  = 8'(rx_cnt);
    assign txlast_all[8*c +: 8] = tx_last_q;
    assign rxhead_all[8*c +: 8] = rx_mem[rx_rp];
    assign rx_ne[c]             = !rx_empty;
  end

  logic [31:0] rd_val;

  // NOTE: rd_val gets its default before the loop so no path infers a latch.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == 13'(c)) begin
        if (rd_addr[2:0] == 3'b000)
          rd_val = {uart_cfg[8*c +: 8], rxcnt_all[8*c +: 8],
                    txlast_all[8*c +: 8], status_all[8*c +: 8]};
        else if (rd_addr[2:0] == 3'b100 && rx_ne[c])
          rd_val = {23'b0, 1'b1, rxhead_all[8*c +: 8]};
      end
    end
  end

  // rdata holds through the cycle rd_rdy falls and clears on the next one.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_rdy <= 1'b0;
      rdata  <= '0;
    end else begin
      rd_rdy <= rd_en;
      if (rd_en)        rdata <= rd_val;
      else if (!rd_rdy) rdata <= '0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{be[2], wdata[23:16], wdata[7:6], wdata[3:0]};

endmodule

// File: tb/tb_uart_regfile_mc.sv
// Self-checking bench for uart_regfile_mc: queue-based channel model checked
// every cycle, plus directed sequences with hand-computed literal values.
module tb_uart_regfile_mc;

  localparam int         NCH     = 2;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] CFG_RST = 8'd18;

  logic               clk = 1'b0;
  logic               rstb = 1'b0;
  logic               wr_en = 1'b0;
  logic [3:0]         be = '0;
  logic [15:0]        wr_addr = '0;
  logic [31:0]        wdata = '0;
  logic               rd_en = 1'b0;
  logic [15:0]        rd_addr = '0;
  logic [31:0]        rdata;
  logic               rd_rdy;
  logic [8*NCH-1:0]   uart_cfg;
  logic [8*NCH-1:0]   tx_data;
  logic [NCH-1:0]     tx_valid;
  logic [NCH-1:0]     tx_ready = '0;
  logic [NCH-1:0]     tx_busy = '0;
  logic [8*NCH-1:0]   rx_data = '0;
  logic [NCH-1:0]     rx_valid = '0;
  logic [NCH-1:0]     irq;

  uart_regfile_mc #(.NCH(NCH), .FIFO_DEPTH(DEPTH), .CFG_RST(CFG_RST)) dut (
    .clk(clk), .rstb(rstb), .wr_en(wr_en), .be(be), .wr_addr(wr_addr),
    .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr), .rdata(rdata),
    .rd_rdy(rd_rdy), .uart_cfg(uart_cfg), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Channel model: byte queues and flags, updated once per clock edge.
  logic [7:0]     txq [NCH][$];
  logic [7:0]     rxq [NCH][$];
  logic [7:0]     m_cfg [NCH];
  logic [7:0]     m_last [NCH];
  bit             m_txovf [NCH];
  bit             m_rxovf [NCH];
  logic [NCH-1:0] m_irq;
  bit             m_rdy;
  logic [31:0]    m_rdata;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      txq[c].delete();
      rxq[c].delete();
      m_cfg[c]   = CFG_RST;
      m_last[c]  = 8'h00;
      m_txovf[c] = 1'b0;
      m_rxovf[c] = 1'b0;
    end
    m_irq   = '0;
    m_rdy   = 1'b0;
    m_rdata = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] a);
    int ch;
    logic [7:0] st;
    ch = int'(a[15:3]);
    if (ch >= NCH) return 32'h0;
    if (a[2:0] == 3'b000) begin
      st = {1'b0, tx_busy[ch], m_txovf[ch], m_rxovf[ch],
            rxq[ch].size() == DEPTH, rxq[ch].size() == 0,
            txq[ch].size() == 0, txq[ch].size() == DEPTH};
      return {m_cfg[ch], 8'(rxq[ch].size()), m_last[ch], st};
    end
    if (a[2:0] == 3'b100 && rxq[ch].size() != 0)
      return {23'b0, 1'b1, rxq[ch].pop_front()};
    return 32'h0;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] irq_n;
    int ch;
    for (int c = 0; c < NCH; c++)
      irq_n[c] = (rxq[c].size() != 0) || m_rxovf[c] || m_txovf[c];
    m_rdy = rd_en;
    if (rd_en) m_rdata = model_read(rd_addr);
    for (int c = 0; c < NCH; c++)
      if (tx_ready[c] && txq[c].size() != 0) void'(txq[c].pop_front());
    if (wr_en && wr_addr[2:0] == 3'b000 && int'(wr_addr[15:3]) < NCH) begin
      ch = int'(wr_addr[15:3]);
      if (be[0]) begin
        if (wdata[4]) m_rxovf[ch] = 1'b0;
        if (wdata[5]) m_txovf[ch] = 1'b0;
      end
      if (be[1]) begin
        m_last[ch] = wdata[15:8];
        if (txq[ch].size() < DEPTH) txq[ch].push_back(wdata[15:8]);
        else m_txovf[ch] = 1'b1;
      end
      if (be[3]) m_cfg[ch] = wdata[31:24];
    end
    for (int c = 0; c < NCH; c++)
      if (rx_valid[c]) begin
        if (rxq[c].size() < DEPTH) rxq[c].push_back(rx_data[8*c +: 8]);
        else m_rxovf[c] = 1'b1;
      end
    m_irq = irq_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstb);
      if (!rstb) model_reset();
      else model_step();
    end
  end

  initial begin : cmp
    logic [8*NCH-1:0] exp_cfg;
    forever begin
      @(negedge clk);
      if (rstb) begin
        check("rd_rdy", rd_rdy, m_rdy);
        if (m_rdy) check("rdata", rdata, m_rdata);
        for (int c = 0; c < NCH; c++) begin
          check("tx_valid", tx_valid[c], txq[c].size() != 0);
          if (txq[c].size() != 0) check("tx_data", tx_data[8*c +: 8], txq[c][0]);
          exp_cfg[8*c +: 8] = m_cfg[c];
        end
        check("irq", irq, m_irq);
        check("uart_cfg", uart_cfg, exp_cfg);
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; be = b; wdata = d;
    @(negedge clk);
    wr_en = 1'b0; be = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
    check("rd_rdy_lat", rd_rdy, 1'b1);
  endtask

  task automatic rx_strobe(input int c, input logic [7:0] b);
    rx_valid[c] = 1'b1; rx_data[8*c +: 8] = b;
    @(negedge clk);
    rx_valid[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] exp_rx [5];
    exp_rx = '{32'h1A1, 32'h1A2, 32'h1A3, 32'h1A4, 32'h000};

    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Reset state
    rd(16'h0000, d);
    check("rst_ctrl0", d, 32'h1200_0006);
    check("rst_txv", tx_valid, 0);
    check("rst_irq", irq, 0);

    // Channel 1 TX push and pop
    wr(16'h0008, 4'b0010, 32'h0000_4100);
    check("ch1_txv", tx_valid[1], 1'b1);
    check("ch1_txd", tx_data[15:8], 8'h41);
    tx_ready[1] = 1'b1;
    @(negedge clk);
    tx_ready[1] = 1'b0;
    check("ch1_txpop", tx_valid[1], 1'b0);
    rd(16'h0008, d);
    check("ch1_ctrl", d, 32'h1200_4106);

    // TX overflow then W1C
    for (int i = 1; i <= 5; i++) wr(16'h0000, 4'b0010, 32'(i) << 8);
    rd(16'h0000, d);
    check("tx_ovf", d, 32'h1200_0525);
    check("irq_txovf", irq[0], 1'b1);
    wr(16'h0000, 4'b0001, 32'h20);
    rd(16'h0000, d);
    check("tx_w1c", d, 32'h1200_0505);
    check("irq_clr", irq[0], 1'b0);
    check("tx_head", tx_data[7:0], 8'h01);
    tx_ready[0] = 1'b1;
    repeat (4) @(negedge clk);
    tx_ready[0] = 1'b0;
    check("tx_drained", tx_valid[0], 1'b0);

    // RX receive, irq, reads
    rx_strobe(0, 8'h11);
    rx_strobe(0, 8'h22);
    check("irq_rx", irq[0], 1'b1);
    rd(16'h0004, d); check("rx_a", d, 32'h111);
    rd(16'h0004, d); check("rx_b", d, 32'h122);
    rd(16'h0004, d); check("rx_empty", d, 32'h000);
    check("irq_rx_drop", irq[0], 1'b0);

    // RX full: push+pop same cycle, then overflow
    for (int i = 0; i < 4; i++) rx_strobe(0, 8'hA0 + 8'(i));
    rx_valid[0] = 1'b1; rx_data[7:0] = 8'hA4; rd_en = 1'b1; rd_addr = 16'h0004;
    @(negedge clk);
    rx_valid[0] = 1'b0; rd_en = 1'b0;
    check("rx_pushpop", rdata, 32'h1A0);
    rd(16'h0000, d);
    check("rx_full_ctrl", d, 32'h1204_050A);
    rx_strobe(0, 8'hA5);
    rd(16'h0000, d);
    check("rx_ovf", d, 32'h1204_051A);

    // Set beats W1C in the same cycle
    rx_valid[0] = 1'b1; rx_data[7:0] = 8'hA6;
    wr(16'h0000, 4'b0001, 32'h10);
    rx_valid[0] = 1'b0;
    rd(16'h0000, d);
    check("set_wins", d, 32'h1204_051A);

    // Read with simultaneous W1C returns pre-write value
    rd_en = 1'b1; rd_addr = 16'h0000;
    wr(16'h0000, 4'b0001, 32'h10);
    rd_en = 1'b0;
    check("rd_prewrite", rdata, 32'h1204_051A);
    rd(16'h0000, d);
    check("rx_w1c", d, 32'h1204_050A);
    for (int i = 0; i < 5; i++) begin
      rd(16'h0004, d);
      check("rx_drain", d, exp_rx[i]);
    end

    // Back-to-back reads keep rd_rdy high
    rd_en = 1'b1; rd_addr = 16'h0008;
    @(negedge clk);
    rd_addr = 16'h0000;
    @(negedge clk);
    rd_en = 1'b0;
    check("b2b_rdy", rd_rdy, 1'b1);
    check("b2b_data", rdata, 32'h1200_0506);

    // Unmapped and misaligned accesses
    rd(16'h0002, d); check("rd_misalign", d, 0);
    rd(16'h0010, d); check("rd_nch", d, 0);
    wr(16'h0010, 4'hF, 32'hFFFF_FFFF);
    wr(16'h0009, 4'hF, 32'hFFFF_FFFF);
    wr(16'h0004, 4'hF, 32'hFFFF_FFFF);
    check("cfg_untouched", uart_cfg, 16'h1212);
    check("bad_wr_txv", tx_valid, 0);
    wr(16'h0008, 4'b1000, 32'h3300_0000);
    check("cfg_wr", uart_cfg, 16'h3312);
    tx_busy[1] = 1'b1;
    rd(16'h0008, d);
    check("tx_busy", d, 32'h3300_4146);
    tx_busy[1] = 1'b0;

    // Reset asserted mid-transfer
    wr(16'h0000, 4'b0010, 32'h7700);
    rx_strobe(1, 8'h55);
    rd_en = 1'b1; rd_addr = 16'h0000;
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check("mr_rdy", rd_rdy, 1'b0);
    check("mr_rdata", rdata, 0);
    check("mr_txv", tx_valid, 0);
    check("mr_irq", irq, 0);
    check("mr_cfg", uart_cfg, 16'h1212);
    rd_en = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    rd(16'h000C, d); check("mr_rx1", d, 0);
    rd(16'h0000, d); check("mr_ctrl0", d, 32'h1200_0006);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
